// File: rtl/cp0_core_if.sv
// CP0 pipeline-facing bundle: mtc0/mfc0 ports, interrupt lines, exception/eret commit, live outputs.
// Latency: reads are combinational; writes and commits land on the next clk edge.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
// Ports: master = pipeline side (drives strobes, reads results), slave = cp0_core.
interface cp0_core_if #(
  parameter int N_HW_INT = 6
);
  logic                wr_en;
  logic [4:0]          wr_addr;
  logic [31:0]         wr_data;
  logic [4:0]          rd_addr;
  logic [31:0]         rd_data;
  logic [N_HW_INT-1:0] hw_int;
  logic                exc_valid;
  logic [4:0]          exc_code;
  logic [31:0]         exc_pc;
  logic                exc_bd;
  logic [31:0]         exc_badvaddr;
  logic                eret;
  logic                int_req;
  logic                timer_int;
  logic [31:0]         status;
  logic [31:0]         cause;
  logic [31:0]         epc;
  logic                exl;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, hw_int,
           exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret,
    input  rd_data, int_req, timer_int, status, cause, epc, exl
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, hw_int,
           exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret,
    output rd_data, int_req, timer_int, status, cause, epc, exl
  );
endinterface

// File: rtl/cp0_core.sv
// CP0 system control: TLB index regs, prescaled Count/Compare timer, masked interrupts, exception/ERET commit.
// Latency: mfc0 read data is combinational from state; mtc0 writes and commits take effect at the next clk edge.
// Backpressure: none; exc_valid overrides eret, which overrides the EXL part of a same-cycle mtc0.
// Ports: clk, rst (async active-low), bus (cp0_core_if.slave) carrying all strobes and live outputs.
module cp0_core #(
  parameter int          N_HW_INT    = 6,
  parameter int          COUNT_DIV   = 2,
  parameter int          TLB_ENTRIES = 16,
  parameter logic [31:0] PRID        = 32'h0001_8000
) (
  input  logic       clk,
  input  logic       rst,
  cp0_core_if.slave  bus
);

  localparam int RW = $clog2(TLB_ENTRIES);
  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  localparam logic [RW-1:0] RAND_TOP  = RW'(TLB_ENTRIES - 1);
  localparam logic [PW-1:0] PRESC_TOP = PW'(COUNT_DIV - 1);

  localparam logic [4:0] REG_INDEX    = 5'd0;
  localparam logic [4:0] REG_RANDOM   = 5'd1;
  localparam logic [4:0] REG_ENTRYLO0 = 5'd2;
  localparam logic [4:0] REG_ENTRYLO1 = 5'd3;
  localparam logic [4:0] REG_WIRED    = 5'd6;
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_ENTRYHI  = 5'd10;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  // Architectural state
  logic [RW-1:0] index_q;
  logic [RW-1:0] random_q;
  logic [RW-1:0] wired_q;
  logic [31:0]   entrylo0_q;
  logic [31:0]   entrylo1_q;
  logic [31:0]   entryhi_q;
  logic [31:0]   badvaddr_q;
  logic [31:0]   count_q;
  logic [31:0]   compare_q;
  logic [31:0]   epc_q;
  logic [7:0]    im_q;
  logic          exl_q;
  logic          ie_q;
  logic          bd_q;
  logic          ti_q;
  logic [1:0]    ip_sw_q;
  logic [5:0]    ip_hw_q;
  logic [4:0]    exc_code_q;
  logic [PW-1:0] presc_q;

  // A committing exception flushes the mtc0 in the same cycle.
  logic mtc0;
  logic wr_index, wr_entrylo0, wr_entrylo1, wr_wired, wr_count;
  logic wr_entryhi, wr_compare, wr_status, wr_cause, wr_epc;

  assign mtc0        = bus.wr_en & ~bus.exc_valid;
  assign wr_index    = mtc0 & (bus.wr_addr == REG_INDEX);
  assign wr_entrylo0 = mtc0 & (bus.wr_addr == REG_ENTRYLO0);
  assign wr_entrylo1 = mtc0 & (bus.wr_addr == REG_ENTRYLO1);
  assign wr_wired    = mtc0 & (bus.wr_addr == REG_WIRED);
  assign wr_count    = mtc0 & (bus.wr_addr == REG_COUNT);
  assign wr_entryhi  = mtc0 & (bus.wr_addr == REG_ENTRYHI);
  assign wr_compare  = mtc0 & (bus.wr_addr == REG_COMPARE);
  assign wr_status   = mtc0 & (bus.wr_addr == REG_STATUS);
  assign wr_cause    = mtc0 & (bus.wr_addr == REG_CAUSE);
  assign wr_epc      = mtc0 & (bus.wr_addr == REG_EPC);

  // Unused hardware lines are tied low so IP bits above N_HW_INT read 0.
  logic [5:0] hw_pad;
  always_comb begin
    hw_pad = '0;
    hw_pad[N_HW_INT-1:0] = bus.hw_int;
  end

  logic presc_tick;
  logic timer_match;
  assign presc_tick  = (presc_q == PRESC_TOP);
  assign timer_match = (compare_q != 32'h0) && (count_q == compare_q);

  logic badvaddr_upd;
  assign badvaddr_upd = (bus.exc_code == 5'h04) || (bus.exc_code == 5'h05);

  // Random free-runs downward between TLB_ENTRIES-1 and Wired.
  logic [RW-1:0] random_nxt;
  always_comb begin
    random_nxt = random_q - RW'(1);
    if (wr_wired || (wired_q >= RAND_TOP) || (random_q == wired_q) || (random_q == '0)) begin
      random_nxt = RAND_TOP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      index_q    <= '0;
      random_q   <= RAND_TOP;
      wired_q    <= '0;
      entrylo0_q <= '0;
      entrylo1_q <= '0;
      entryhi_q  <= '0;
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      epc_q      <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      exc_code_q <= '0;
      presc_q    <= '0;
    end else begin
      random_q <= random_nxt;
      ip_hw_q  <= hw_pad;

      // Count write restarts the prescaler so the first tick is COUNT_DIV cycles later.
      if (wr_count) begin
        count_q <= bus.wr_data;
        presc_q <= '0;
      end else if (presc_tick) begin
        count_q <= count_q + 32'd1;
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + PW'(1);
      end

      // TI is sticky; a Compare write beats a coincident match.
      if (wr_compare) begin
        compare_q <= bus.wr_data;
        ti_q      <= 1'b0;
      end else if (timer_match) begin
        ti_q <= 1'b1;
      end

      if (wr_index)    index_q    <= bus.wr_data[RW-1:0];
      if (wr_wired)    wired_q    <= bus.wr_data[RW-1:0];
      if (wr_entrylo0) entrylo0_q <= bus.wr_data;
      if (wr_entrylo1) entrylo1_q <= bus.wr_data;
      if (wr_entryhi)  entryhi_q  <= bus.wr_data;
      if (wr_cause)    ip_sw_q    <= bus.wr_data[9:8];
      if (wr_status) begin
        im_q <= bus.wr_data[15:8];
        ie_q <= bus.wr_data[0];
      end

      if (bus.exc_valid) begin
        exl_q      <= 1'b1;
        exc_code_q <= bus.exc_code;
        if (badvaddr_upd) badvaddr_q <= bus.exc_badvaddr;
        // Nested exceptions keep the original return point.
        if (!exl_q) begin
          epc_q <= bus.exc_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;
          bd_q  <= bus.exc_bd;
        end
      end else begin
        if (bus.eret)       exl_q <= 1'b0;
        else if (wr_status) exl_q <= bus.wr_data[1];
        if (wr_epc) epc_q <= bus.wr_data;
      end
    end
  end

  logic [7:0]  ip_w;
  logic [31:0] status_w;
  logic [31:0] cause_w;

  assign ip_w     = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};
  assign status_w = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_w  = {bd_q, ti_q, 14'b0, ip_w, 1'b0, exc_code_q, 2'b0};

  logic [31:0] rd_w;
  always_comb begin
    rd_w = 32'h0;
    case (bus.rd_addr)
      REG_INDEX:    rd_w = {{(32-RW){1'b0}}, index_q};
      REG_RANDOM:   rd_w = {{(32-RW){1'b0}}, random_q};
      REG_ENTRYLO0: rd_w = entrylo0_q;
      REG_ENTRYLO1: rd_w = entrylo1_q;
      REG_WIRED:    rd_w = {{(32-RW){1'b0}}, wired_q};
      REG_BADVADDR: rd_w = badvaddr_q;
      REG_COUNT:    rd_w = count_q;
      REG_ENTRYHI:  rd_w = entryhi_q;
      REG_COMPARE:  rd_w = compare_q;
      REG_STATUS:   rd_w = status_w;
      REG_CAUSE:    rd_w = cause_w;
      REG_EPC:      rd_w = epc_q;
      REG_PRID:     rd_w = PRID;
      default:      rd_w = 32'h0;
    endcase
  end

  assign bus.rd_data   = rd_w;
  assign bus.int_req   = ie_q & ~exl_q & (|(im_q & ip_w));
  assign bus.timer_int = ti_q;
  assign bus.status    = status_w;
  assign bus.cause     = cause_w;
  assign bus.epc       = epc_q;
  assign bus.exl       = exl_q;

endmodule
